// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (core / aux) arbiter onto a single-port 1-cycle data
//            memory. Core has priority. Optional starvation relief for aux is
//            compiled in with macro DMEM_ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coreRen,
    input  logic        coreWen,
    input  logic [31:0] coreAddr,
    input  logic [31:0] coreWdata,
    input  logic [2:0]  coreSize,
    output logic [31:0] coreRdata,
    output logic        coreStall,
    input  logic        auxRen,
    input  logic        auxWen,
    input  logic [31:0] auxAddr,
    input  logic [31:0] auxWdata,
    input  logic [2:0]  auxSize,
    output logic        auxGnt,
    output logic        auxRvalid,
    output logic [31:0] auxRdata,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic [2:0]  dmemSize,
    output logic        dmemWen,
    output logic        dmemRen,
    input  logic [31:0] dmemRdata
);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_AUX  = 1'b1
    } owner_e;

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    logic   coreReq;
    logic   auxReq;
    logic   forceAux;
    logic   coreGrant;
    logic   auxGrant;
    logic   rdPending_q, rdPending_d;
    owner_e rdOwner_q,   rdOwner_d;

    assign coreReq   = coreRen | coreWen;
    assign auxReq    = auxRen | auxWen;
    assign coreGrant = coreReq & ~forceAux;
    assign auxGrant  = auxReq & ~coreGrant;

    // A port raising both Ren and Wen performs a write, never a read.
    always_comb begin
        rdPending_d = 1'b0;
        rdOwner_d   = OWN_CORE;
        if (coreGrant && coreRen && !coreWen) begin
            rdPending_d = 1'b1;
        end else if (auxGrant && auxRen && !auxWen) begin
            rdPending_d = 1'b1;
            rdOwner_d   = OWN_AUX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPending_q <= 1'b0;
            rdOwner_q   <= OWN_CORE;
        end else begin
            rdPending_q <= rdPending_d;
            rdOwner_q   <= rdOwner_d;
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starveCnt_q, starveCnt_d;

    assign forceAux = (starveCnt_q == c_STARVE_LIMIT) & auxReq;

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!auxReq || auxGrant) begin
            starveCnt_d = 8'd0;
        end else if (starveCnt_q != c_STARVE_LIMIT) begin
            starveCnt_d = starveCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt_q <= 8'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`else
    assign forceAux = 1'b0;
`endif

    // Every output is gated by rst so the port goes quiet the moment reset rises.
    always_comb begin
        dmemAddr  = '0;
        dmemWdata = '0;
        dmemSize  = '0;
        dmemWen   = 1'b0;
        dmemRen   = 1'b0;
        if (!rst) begin
            if (coreGrant) begin
                dmemAddr  = coreAddr;
                dmemWdata = coreWdata;
                dmemSize  = coreSize;
                dmemWen   = coreWen;
                dmemRen   = coreRen & ~coreWen;
            end else if (auxGrant) begin
                dmemAddr  = auxAddr;
                dmemWdata = auxWdata;
                dmemSize  = auxSize;
                dmemWen   = auxWen;
                dmemRen   = auxRen & ~auxWen;
            end
        end
    end

    assign coreStall = ~rst & coreReq & ~coreGrant;
    assign auxGnt    = ~rst & auxGrant;
    assign auxRvalid = ~rst & rdPending_q & (rdOwner_q == OWN_AUX);
    assign auxRdata  = auxRvalid ? dmemRdata : '0;
    assign coreRdata = (~rst & rdPending_q & (rdOwner_q == OWN_CORE)) ? dmemRdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int c_LIMIT = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit c_STARVE_ON = 1'b1;
`else
    localparam bit c_STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        coreRen, coreWen, auxRen, auxWen;
    logic [31:0] coreAddr, coreWdata, auxAddr, auxWdata, dmemRdata;
    logic [2:0]  coreSize, auxSize;
    logic [31:0] coreRdata, auxRdata, dmemAddr, dmemWdata;
    logic        coreStall, auxGnt, auxRvalid, dmemWen, dmemRen;
    logic [2:0]  dmemSize;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: outstanding read (and whose) plus how long aux has waited.
    bit m_pend;
    bit m_pend_aux;
    int m_wait;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(c_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .coreRen(coreRen), .coreWen(coreWen), .coreAddr(coreAddr),
        .coreWdata(coreWdata), .coreSize(coreSize), .coreRdata(coreRdata),
        .coreStall(coreStall),
        .auxRen(auxRen), .auxWen(auxWen), .auxAddr(auxAddr),
        .auxWdata(auxWdata), .auxSize(auxSize), .auxGnt(auxGnt),
        .auxRvalid(auxRvalid), .auxRdata(auxRdata),
        .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemSize(dmemSize),
        .dmemWen(dmemWen), .dmemRen(dmemRen), .dmemRdata(dmemRdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_core(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] s);
        coreRen = r; coreWen = w; coreAddr = a; coreWdata = d; coreSize = s;
    endtask

    task automatic set_aux(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] s);
        auxRen = r; auxWen = w; auxAddr = a; auxWdata = d; auxSize = s;
    endtask

    // Who owns the memory this cycle, from the priority rules alone.
    task automatic model_grants(output bit cg, output bit ag);
        bit creq, areq, force_a;
        creq    = coreRen | coreWen;
        areq    = auxRen | auxWen;
        force_a = c_STARVE_ON && areq && (m_wait >= c_LIMIT);
        cg      = creq && !force_a;
        ag      = areq && !cg;
    endtask

    task automatic compare_all();
        bit cg, ag;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [2:0]  e_size;
        bit e_wen, e_ren, e_stall, e_gnt, e_arv, e_crv;
        model_grants(cg, ag);
        e_addr = '0; e_wdata = '0; e_size = '0; e_wen = 0; e_ren = 0;
        if (cg) begin
            e_addr = coreAddr; e_wdata = coreWdata; e_size = coreSize;
            e_wen = coreWen; e_ren = coreRen && !coreWen;
        end else if (ag) begin
            e_addr = auxAddr; e_wdata = auxWdata; e_size = auxSize;
            e_wen = auxWen; e_ren = auxRen && !auxWen;
        end
        e_stall = (coreRen | coreWen) && !cg;
        e_gnt   = ag;
        e_arv   = m_pend && m_pend_aux;
        e_crv   = m_pend && !m_pend_aux;
        if (rst) begin
            e_addr = '0; e_wdata = '0; e_size = '0; e_wen = 0; e_ren = 0;
            e_stall = 0; e_gnt = 0; e_arv = 0; e_crv = 0;
        end
        e_rd = dmemRdata;
        check_eq("dmemAddr",  dmemAddr,  e_addr);
        check_eq("dmemWdata", dmemWdata, e_wdata);
        check_eq("dmemSize",  {29'd0, dmemSize}, {29'd0, e_size});
        check_eq("dmemWen",   {31'd0, dmemWen},  {31'd0, e_wen});
        check_eq("dmemRen",   {31'd0, dmemRen},  {31'd0, e_ren});
        check_eq("coreStall", {31'd0, coreStall}, {31'd0, e_stall});
        check_eq("auxGnt",    {31'd0, auxGnt},    {31'd0, e_gnt});
        check_eq("auxRvalid", {31'd0, auxRvalid}, {31'd0, e_arv});
        check_eq("auxRdata",  auxRdata,  e_arv ? e_rd : 32'd0);
        check_eq("coreRdata", coreRdata, e_crv ? e_rd : 32'd0);
    endtask

    task automatic model_edge();
        bit cg, ag;
        if (rst) begin
            m_pend = 0; m_pend_aux = 0; m_wait = 0;
        end else begin
            model_grants(cg, ag);
            m_pend     = (cg && coreRen && !coreWen) || (ag && auxRen && !auxWen);
            m_pend_aux = ag && auxRen && !auxWen;
            if (ag || !(auxRen | auxWen)) m_wait = 0;
            else if (m_wait < c_LIMIT)    m_wait = m_wait + 1;
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_gnt, second_gnt, stall_at_gnt, rv_after, n_gnt, n_stall;
        rst = 1'b1;
        dmemRdata = 32'h0;
        set_core(0, 0, 0, 0, 0);
        set_aux(0, 0, 0, 0, 0);
        m_pend = 0; m_pend_aux = 0; m_wait = 0;

        // Requests during reset are ignored and all outputs are quiet.
        @(negedge clk);
        set_core(1, 0, 32'h100, 0, 3'd2);
        set_aux(0, 1, 32'h200, 32'h55, 3'd2);
        dmemRdata = 32'hA5A5A5A5;
        tick();
        check_eq("rst_stall", {31'd0, coreStall}, 32'd0);
        rst = 1'b0;
        set_core(0, 0, 0, 0, 0);
        set_aux(0, 0, 0, 0, 0);
        tick();

        // Core read, data returned one cycle later.
        set_core(1, 0, 32'h100, 0, 3'd2);
        #1;
        check_eq("r030_ren",   {31'd0, dmemRen}, 32'd1);
        check_eq("r030_addr",  dmemAddr, 32'h100);
        check_eq("r030_stall", {31'd0, coreStall}, 32'd0);
        tick();
        set_core(0, 0, 0, 0, 0);
        dmemRdata = 32'hDEADBEEF;
        #1 check_eq("r030_rdata", coreRdata, 32'hDEADBEEF);
        tick();

        // Simultaneous writes: core first, aux the following cycle.
        set_core(0, 1, 32'h10, 32'h1111, 3'd2);
        set_aux(0, 1, 32'h20, 32'h2222, 3'd2);
        #1;
        check_eq("r031_addr0", dmemAddr, 32'h10);
        check_eq("r031_stall", {31'd0, coreStall}, 32'd0);
        check_eq("r031_gnt0",  {31'd0, auxGnt}, 32'd0);
        tick();
        set_core(0, 0, 0, 0, 0);
        #1;
        check_eq("r031_addr1", dmemAddr, 32'h20);
        check_eq("r031_gnt1",  {31'd0, auxGnt}, 32'd1);
        tick();
        set_aux(0, 0, 0, 0, 0);
        tick();

        // Core hogs the port while aux keeps asking for a read of 0x40.
        first_gnt = 0; second_gnt = 0; stall_at_gnt = 0; rv_after = 0; n_gnt = 0; n_stall = 0;
        set_aux(1, 0, 32'h40, 0, 3'd2);
        for (int i = 1; i <= 100; i++) begin
            set_core(1, 0, $urandom() & 32'hFFFC, 0, 3'd2);
            dmemRdata = $urandom();
            #1;
            if (auxGnt) begin
                n_gnt++;
                if (first_gnt == 0) begin
                    first_gnt = i;
                    stall_at_gnt = coreStall;
                end else if (second_gnt == 0) begin
                    second_gnt = i;
                end
            end
            if (coreStall) n_stall++;
            if (first_gnt != 0 && i == first_gnt + 1) rv_after = auxRvalid;
            tick();
        end
`ifdef DMEM_ARB_STARVE_EN
        check_eq("r032_first_gnt",  first_gnt, 32'd9);
        check_eq("r032_second_gnt", second_gnt, 32'd18);
        check_eq("r032_stall",      stall_at_gnt, 32'd1);
        check_eq("r032_rvalid",     rv_after, 32'd1);
        check_eq("r032_n_gnt",      n_gnt, 32'd11);
`else
        check_eq("r033_n_gnt",   n_gnt, 32'd0);
        check_eq("r033_n_stall", n_stall, 32'd0);
`endif
        set_core(0, 0, 0, 0, 0);
        set_aux(0, 0, 0, 0, 0);
        tick();
        tick();

        // Async reset between an aux read grant and its return.
        set_aux(1, 0, 32'h80, 0, 3'd2);
        dmemRdata = 32'hCAFEF00D;
        #1 compare_all();
        check_eq("r034_gnt", {31'd0, auxGnt}, 32'd1);
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1;
        m_pend = 0; m_pend_aux = 0; m_wait = 0;
        check_eq("r034_rvalid", {31'd0, auxRvalid}, 32'd0);
        check_eq("r034_ren",    {31'd0, dmemRen}, 32'd0);
        check_eq("r034_addr",   dmemAddr, 32'd0);
        compare_all();
        @(negedge clk);
        tick();
        rst = 1'b0;
        set_aux(0, 0, 0, 0, 0);
        #1 check_eq("r026_rvalid", {31'd0, auxRvalid}, 32'd0);
        tick();

        // Alternating core / aux reads: data follows its owner.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                set_core(1, 0, 32'h300 + i, 0, 3'd2);
                set_aux(0, 0, 0, 0, 0);
            end else begin
                set_core(0, 0, 0, 0, 0);
                set_aux(1, 0, 32'h400 + i, 0, 3'd2);
            end
            dmemRdata = $urandom();
            #1;
            if (i > 0) check_eq("r035_rvalid", {31'd0, auxRvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        set_core(0, 0, 0, 0, 0);
        set_aux(0, 0, 0, 0, 0);
        tick();

        // Randomized traffic; aux tends to hold its request and may change content while waiting.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0)
                set_core($urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom(),
                         3'($urandom_range(0, 7)));
            else
                set_core(0, 0, $urandom(), $urandom(), 3'($urandom_range(0, 7)));
            if (!(auxRen | auxWen) || $urandom_range(0, 9) == 0)
                set_aux($urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom(),
                        3'($urandom_range(0, 7)));
            else if ($urandom_range(0, 4) == 0)
                auxAddr = $urandom();
            dmemRdata = $urandom();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, meaning consecutive blocked aux cycles before aux is forced a grant (legal range 1..255).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 coreRen/coreWen  in  1 each  core load/store request from the memory stage.
REQ-005 coreAddr/coreWdata  in  32 each  core address and store data; coreSize  in  3  load/store size.
REQ-006 coreRdata  out  32  load data, valid the cycle after the core read grant.
REQ-007 coreStall  out  1  core request blocked this cycle; the core holds its request stable.
REQ-008 auxRen/auxWen  in  1 each; auxAddr/auxWdata  in  32 each; auxSize  in  3  secondary requester (debug/DMA).
REQ-009 auxGnt  out  1  aux request accepted this cycle.
REQ-010 auxRvalid  out  1  and auxRdata  out  32  aux read data, one cycle after an aux read grant.
REQ-011 dmemAddr/dmemWdata  out  32 each; dmemSize  out  3; dmemWen/dmemRen  out  1 each; dmemRdata  in  32  single-port data memory with fixed 1-cycle read latency, always ready.

Function
REQ-012 coreReq = coreRen|coreWen; auxReq = auxRen|auxWen; if Ren and Wen are both high on one port, the access is a write.
REQ-013 Grant is combinational each cycle: core wins when coreReq and forceAux=0; otherwise aux wins when auxReq; otherwise there is no grant.
REQ-014 coreStall = coreReq & ~coreGrant; auxGnt = auxReq & auxGrant.
REQ-015 dmem* outputs carry the granted port's fields; with no grant, all dmem* outputs are 0.
REQ-016 Registered return tag: rdOwner (CORE/AUX) and rdPending are set on a read grant and cleared otherwise.
REQ-017 auxRvalid = rdPending & (rdOwner==AUX); auxRdata = dmemRdata when auxRvalid, else 0.
REQ-018 coreRdata = dmemRdata when rdPending & (rdOwner==CORE), else 0.
REQ-019 Back-to-back grants to either port are allowed every cycle; there are no idle bubbles.
REQ-020 Starvation counter starveCnt (8 bit) increments when auxReq & ~auxGnt, saturates at STARVE_LIMIT, and clears to 0 on auxGnt or when auxReq is low.
REQ-021 forceAux = (starveCnt==STARVE_LIMIT) & auxReq; it lasts exactly one grant, and the counter clears on that grant.
REQ-022 Simultaneous core and aux requests with forceAux=0: core is granted and aux waits (coreStall=0, auxGnt=0).
REQ-023 A change in aux request content while it is waiting is permitted; only the content present in the grant cycle is issued.

Reset
REQ-024 Asserting rst clears rdPending, rdOwner (to CORE) and starveCnt to 0 asynchronously.
REQ-025 During rst, all outputs are 0, including coreStall, auxGnt, auxRvalid and dmemWen/dmemRen; requests are ignored.
REQ-026 Reset asserted mid-read discards the pending return, so no auxRvalid follows.
REQ-027 After rst deasserts, the first cycle arbitrates normally.

Configuration
REQ-028 Macro DMEM_ARB_STARVE_EN, when defined, compiles in the starvation counter and forceAux (REQ-020/021).
REQ-029 When DMEM_ARB_STARVE_EN is undefined, arbitration is strict core priority, forceAux is constant 0, the counter is absent, and aux can wait indefinitely.

Verification
REQ-030 Core read only, addr 0x100, dmemRdata=0xDEADBEEF next cycle -> dmemRen=1, dmemAddr=0x100, coreStall=0, and coreRdata=0xDEADBEEF one cycle later.
REQ-031 Core and aux write together at 0x10 and 0x20 -> dmemAddr=0x10, coreStall=0, auxGnt=0; next cycle with core idle -> dmemAddr=0x20, auxGnt=1.
REQ-032 With DMEM_ARB_STARVE_EN and STARVE_LIMIT=8, core requests continuously and aux reads 0x40 -> aux is blocked 8 cycles, the 9th cycle gives auxGnt=1 and coreStall=1, auxRvalid follows, and the counter returns to 0.
REQ-033 Same stimulus as REQ-032 without DMEM_ARB_STARVE_EN -> auxGnt stays 0 for 100 cycles and coreStall stays 0.
REQ-034 Aux read granted, then rst asserted asynchronously before the next edge -> auxRvalid=0 and all dmem* outputs are 0 immediately.
REQ-035 Alternating core and aux reads every cycle with no overlap -> each rdata is routed only to its owner, and auxRvalid toggles in step with each aux grant.
